// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type, lane count and request-classification helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LANES = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Unsigned variants exist only for loads; 011/11x are never legal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering: store byte enables and replication,
// load byte/half extraction with sign or zero extension.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [DATA_W-1:0] ld_word_i,
  output logic [LANES-1:0]  byte_en_o,
  output logic [DATA_W-1:0] st_word_o,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store side: replicate the datum across lanes, enables select the target.
  always_comb begin
    byte_en_o = {LANES{1'b0}};
    st_word_o = st_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        byte_en_o = 4'b0001 << addr_lo_i;
        st_word_o = {(DATA_W/8){st_data_i[7:0]}};
      end
      2'b01: begin
        byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_word_o = {(DATA_W/16){st_data_i[15:0]}};
      end
      2'b10: begin
        byte_en_o = 4'b1111;
        st_word_o = st_data_i;
      end
      default: begin
        byte_en_o = 4'b0000;
        st_word_o = st_data_i;
      end
    endcase
  end

  // Load side: pick the addressed byte/half and extend to the full word.
  always_comb begin
    ld_byte_s = ld_word_i[{addr_lo_i, 3'b000} +: 8];
    ld_half_s = ld_word_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    ld_data_o = {{(DATA_W-8){ld_byte_s[7]}}, ld_byte_s};
      F3_H:    ld_data_o = {{(DATA_W-16){ld_half_s[15]}}, ld_half_s};
      F3_W:    ld_data_o = ld_word_i;
      F3_BU:   ld_data_o = {{(DATA_W-8){1'b0}}, ld_byte_s};
      F3_HU:   ld_data_o = {{(DATA_W-16){1'b0}}, ld_half_s};
      default: ld_data_o = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory with a one-cycle load response FSM.
// Optional build macro: DMEM_MISALIGN_CHECK_EN (reject misaligned half/word accesses).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        addr_lo_s;
  logic [ADDR_W-3:0] word_idx_s;
  logic              misalign_s;
  logic              idle_s;
  logic              ld_go_s;
  logic              st_go_s;
  logic              reject_s;
  logic [LANES-1:0]  byte_en_s;
  logic [DATA_W-1:0] st_word_s;
  logic [DATA_W-1:0] ld_word_s;
  logic [DATA_W-1:0] ld_data_s;

  // Effective lane offset: either flag misalignment or silently align it.
  always_comb begin
    word_idx_s = addr[ADDR_W-1:2];
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign_s = misaligned(funct3, addr[1:0]);
    addr_lo_s  = addr[1:0];
`else
    misalign_s = 1'b0;
    if (funct3[1:0] == 2'b01) begin
      addr_lo_s = {addr[1], 1'b0};
    end else if (funct3[1:0] == 2'b10) begin
      addr_lo_s = 2'b00;
    end else begin
      addr_lo_s = addr[1:0];
    end
`endif
  end

  assign idle_s    = (state_q == ST_IDLE);
  assign ld_go_s   = idle_s & rd & ~wr & f3_legal(funct3, 1'b0) & ~misalign_s;
  assign st_go_s   = reset & idle_s & wr & ~rd & f3_legal(funct3, 1'b1) & ~misalign_s;
  assign reject_s  = idle_s & (rd | wr) & ~ld_go_s & ~st_go_s;
  assign ld_word_s = mem_q[word_idx_s];

  dmem_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .funct3_i (funct3),
    .addr_lo_i(addr_lo_s),
    .st_data_i(wr_data),
    .ld_word_i(ld_word_s),
    .byte_en_o(byte_en_s),
    .st_word_o(st_word_s),
    .ld_data_o(ld_data_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RESP always lasts exactly one cycle.
  always_comb begin
    case (state_q)
      ST_IDLE: state_d = ld_go_s ? ST_RESP : ST_IDLE;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values; the load result is captured at acceptance so it
  // appears together with rd_valid in the RESP cycle.
  always_comb begin
    rd_valid_d = ld_go_s;
    err_d      = reject_s;
    if (ld_go_s) begin
      rd_data_d = ld_data_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (st_go_s) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (byte_en_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= st_word_s[8*i +: 8];
        end
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = (state_q == ST_RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array model.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        err;

  int          n_cmp;
  int          n_mis;
  logic [7:0]  mb [512];
  logic [31:0] last_rd;

  data_mem_responder #(
    .DATA_W(32),
    .ADDR_W(9)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .funct3  (funct3),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: kind 0 = nothing visible, 1 = load response, 2 = error pulse.
  task automatic model(input logic w, input logic r, input logic [8:0] a, input logic [2:0] f,
                       input logic [31:0] d, output int kind, output logic [31:0] ev);
    int  size;
    int  base;
    logic ok;
    kind = 0;
    ev   = 32'h0;
    if (w || r) begin
      size = 1 << f[1:0];
      if (w && r)  ok = 1'b0;
      else if (r)  ok = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
      else         ok = (f == 3'd0 || f == 3'd1 || f == 3'd2);
`ifdef DMEM_MISALIGN_CHECK_EN
      if (ok && (int'(a) % size) != 0) ok = 1'b0;
`endif
      if (!ok) begin
        kind = 2;
      end else begin
        base = int'(a) - (int'(a) % size);
        if (w) begin
          for (int k = 0; k < size; k++) mb[base + k] = 8'(d >> (8 * k));
        end else begin
          kind = 1;
          for (int k = 0; k < size; k++) ev = ev | (32'(mb[base + k]) << (8 * k));
          if (!f[2] && size < 4 && ev[8 * size - 1]) ev = ev | (32'hFFFF_FFFF << (8 * size));
        end
      end
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [8:0] a, input logic [2:0] f,
                      input logic [31:0] d, input logic poke);
    int          kind;
    logic [31:0] ev;
    model(w, r, a, f, d, kind, ev);
    wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    if (kind == 1) last_rd = ev;
    check_eq("rd_valid", 32'(rd_valid), 32'(kind == 1));
    check_eq("err", 32'(err), 32'(kind == 2));
    check_eq("busy", 32'(busy), 32'(kind == 1));
    check_eq("rd_data", rd_data, last_rd);
    if (kind == 1) begin
      if (poke) begin
        rd = 1'b1;
        wr = 1'($urandom_range(0, 1));
        addr = 9'($urandom);
        funct3 = 3'($urandom_range(0, 2));
        wr_data = $urandom;
      end
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
      check_eq("resp_valid_drop", 32'(rd_valid), 32'h0);
      check_eq("resp_err_drop", 32'(err), 32'h0);
      check_eq("resp_busy_drop", 32'(busy), 32'h0);
      check_eq("resp_data_hold", rd_data, last_rd);
    end
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; last_rd = 32'h0;
    reset = 1'b0; wr = 1'b0; rd = 1'b0; addr = 9'h0; funct3 = 3'b000; wr_data = 32'h0;
    #1;
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Fill every word so later loads never see unwritten storage.
    for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 9'(i * 4), 3'b010, $urandom, 1'b0);

    step(1'b1, 1'b0, 9'h010, 3'b010, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0);
    check_eq("lw_010", rd_data, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 9'h013, 3'b000, 32'h0000_0080, 1'b0);
    step(1'b0, 1'b1, 9'h013, 3'b000, 32'h0, 1'b0);
    check_eq("lb_013", rd_data, 32'hFFFF_FF80);
    step(1'b0, 1'b1, 9'h013, 3'b100, 32'h0, 1'b0);
    check_eq("lbu_013", rd_data, 32'h0000_0080);
    step(1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0);
    check_eq("lw_010_merged", rd_data, 32'h80AD_BEEF);
    step(1'b1, 1'b0, 9'h022, 3'b001, 32'h0000_8001, 1'b0);
    step(1'b0, 1'b1, 9'h022, 3'b001, 32'h0, 1'b0);
    check_eq("lh_022", rd_data, 32'hFFFF_8001);
    step(1'b0, 1'b1, 9'h022, 3'b101, 32'h0, 1'b0);
    check_eq("lhu_022", rd_data, 32'h0000_8001);
    step(1'b1, 1'b1, 9'h010, 3'b010, 32'h1234_5678, 1'b0);
    step(1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b1);
    check_eq("rdwr_unchanged", rd_data, 32'h80AD_BEEF);
    step(1'b1, 1'b0, 9'h010, 3'b100, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, 9'h010, 3'b011, 32'h0, 1'b0);
    step(1'b0, 1'b1, 9'h011, 3'b010, 32'h0, 1'b0);
`ifndef DMEM_MISALIGN_CHECK_EN
    check_eq("lw_011_aligned", rd_data, 32'h80AD_BEEF);
`endif

    // Reset while the response is pending.
    rd = 1'b1; addr = 9'h020; funct3 = 3'b010;
    @(posedge clk); #1;
    rd = 1'b0;
    reset = 1'b0;
    #1;
    last_rd = 32'h0;
    check_eq("rstresp_busy", 32'(busy), 32'h0);
    check_eq("rstresp_valid", 32'(rd_valid), 32'h0);
    check_eq("rstresp_data", rd_data, 32'h0);
    @(posedge clk); #1;
    check_eq("rstresp_valid_later", 32'(rd_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      step(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8, 9'($urandom),
           (op < 8 && $urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom),
           $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
